// File: rtl/comp_nbit_bist.sv
// comp_nbit_bist: built-in self-test that sweeps and randomly exercises an n-bit magnitude comparator and checks every response
module comp_nbit_bist #(
    parameter int          n     = 4,
    parameter int          NRAND = 10,
    parameter int          LAT   = 0,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [n-1:0] a,
    output logic [n-1:0] b,
    input  logic         gt,
    input  logic         eq,
    input  logic         lt,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic [n-1:0] fail_a,
    output logic [n-1:0] fail_b
);
    localparam int          W        = 2 * n;
    localparam int          CW       = W + 1;
    localparam int          PL       = (LAT > 0) ? LAT : 1;
    localparam int          E        = W + 4;
    localparam logic [31:0] MASK     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [2:0] {IDLE, SWEEP, RAND, DRAIN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] vcnt;
    logic [CW-1:0] vnext;
    logic [15:0]   rcnt;
    logic [31:0]   lfsr;
    logic [31:0]   lfsr_next;
    logic          first_seen;
    logic [E-1:0]  pipe [PL];
    logic [E-1:0]  cur;
    logic [E-1:0]  chk;
    logic          mism;
    logic [15:0]   err_next;
    logic          sweep_end;
    logic          rand_end;
    logic          drain_end;
    logic          to_done;

    // Entry layout {valid, a, b, expected gt/eq/lt}; the checked entry is the live vector or the one delayed LAT cycles
    always_comb begin
        cur       = {(state == SWEEP) || (state == RAND), a, b, a > b, a == b, a < b};
        chk       = (LAT == 0) ? cur : pipe[PL-1];
        mism      = chk[E-1] && (chk[2:0] != {gt, eq, lt});
        err_next  = (mism && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
        vnext     = vcnt + 1'b1;
        sweep_end = (state == SWEEP) && vnext[W];
        rand_end  = (state == RAND) && (rcnt == 16'(NRAND - 1));
        drain_end = (state == DRAIN) && (rcnt == 16'(LAT - 1));
        to_done   = (sweep_end && NRAND == 0 && LAT == 0) || (rand_end && LAT == 0) || drain_end;
    end

    // Sequencer, response pipeline, error accounting and first-failure capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            vcnt       <= '0;
            rcnt       <= '0;
            lfsr       <= SEED_EFF;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            first_seen <= 1'b0;
            for (int i = 0; i < PL; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
            err_count <= err_next;
            if (mism && !first_seen) begin
                first_seen <= 1'b1;
                fail_a     <= chk[E-2 -: n];
                fail_b     <= chk[E-2-n -: n];
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= SWEEP;
                    {a, b}     <= '0;
                    vcnt       <= '0;
                    lfsr       <= SEED_EFF;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    pass       <= 1'b0;
                    err_count  <= '0;
                    fail_a     <= '0;
                    fail_b     <= '0;
                    first_seen <= 1'b0;
                end
                SWEEP: if (!sweep_end) begin
                    vcnt   <= vnext;
                    {a, b} <= vnext[W-1:0];
                end else if (NRAND > 0) begin
                    state  <= RAND;
                    {a, b} <= lfsr[W-1:0];
                    lfsr   <= lfsr_next;
                    rcnt   <= '0;
                end else if (LAT > 0) begin
                    state <= DRAIN;
                    rcnt  <= '0;
                end
                RAND: if (!rand_end) begin
                    {a, b} <= lfsr[W-1:0];
                    lfsr   <= lfsr_next;
                    rcnt   <= rcnt + 16'd1;
                end else if (LAT > 0) begin
                    state <= DRAIN;
                    rcnt  <= '0;
                end
                DRAIN: if (!drain_end) rcnt <= rcnt + 16'd1;
                default: state <= IDLE;
            endcase
            if (to_done) begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                pass   <= (err_next == 16'd0);
                {a, b} <= '0;
            end
        end
    end
endmodule

// File: tb/tb_comp_nbit_bist.sv
// tb_comp_nbit_bist: scoreboard bench for the comparator BIST with faulty, combinational and registered comparators
module tb_comp_nbit_bist;
    localparam int N  = 4;
    localparam int NR = 10;
    localparam int NV = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [N-1:0] a0, b0, a1, b1, a2, b2, fa0, fb0, fa1, fb1, fa2, fb2;
    logic [N-1:0] ra1, rb1, ra2, rb2;
    logic [2:0]   r1, r2;
    logic         gt0, eq0, lt0, gt1, eq1, lt1, gt2, eq2, lt2;
    logic         busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0]  ec0, ec1, ec2;

    always #5 clk = ~clk;

    function automatic logic [2:0] cmp(input int m, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2:0] r;
        r = {x > y, x == y, x < y};
        if (m == 1) r[1] = 1'b0;
        if (m == 2 && x == 4'd3 && y == 4'd2) r = 3'b001;
        return r;
    endfunction

    always_comb {gt0, eq0, lt0} = cmp(mode, a0, b0);

    always_ff @(posedge clk) begin
        ra1 <= a1;
        rb1 <= b1;
        r1  <= cmp(0, ra1, rb1);
        ra2 <= a2;
        rb2 <= b2;
        r2  <= cmp(0, ra2, rb2);
    end

    assign {gt1, eq1, lt1} = r1;
    assign {gt2, eq2, lt2} = r2;

    comp_nbit_bist #(.n(N), .NRAND(NR), .LAT(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0),
        .gt(gt0), .eq(eq0), .lt(lt0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(ec0), .fail_a(fa0), .fail_b(fb0));

    comp_nbit_bist #(.n(N), .NRAND(NR), .LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1),
        .gt(gt1), .eq(eq1), .lt(lt1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .fail_a(fa1), .fail_b(fb1));

    comp_nbit_bist #(.n(N), .NRAND(NR), .LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2),
        .gt(gt2), .eq(eq2), .lt(lt2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(ec2), .fail_a(fa2), .fail_b(fb2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int m, input int restart_at, input int abort_at);
        logic [2*N-1:0] vq[$];
        logic [2*N-1:0] v;
        logic [31:0]    l;
        logic [N-1:0]   efa, efb;
        bit             seen;
        int             e_err, e_part, bc0, bc1, bc2, cyc;
        l = 32'd1;
        for (int i = 0; i < NV; i++) vq.push_back((2*N)'(i));
        for (int j = 0; j < NR; j++) begin
            vq.push_back(l[2*N-1:0]);
            l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        end
        e_err = 0; e_part = 0; seen = 0; efa = '0; efb = '0;
        for (int i = 0; i < vq.size(); i++) begin
            if (cmp(m, vq[i][2*N-1:N], vq[i][N-1:0]) != cmp(0, vq[i][2*N-1:N], vq[i][N-1:0])) begin
                e_err++;
                if (i < abort_at) e_part++;
                if (!seen) begin
                    seen = 1;
                    efa  = vq[i][2*N-1:N];
                    efb  = vq[i][N-1:0];
                end
            end
        end
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc0 = 0; bc1 = 0; bc2 = 0; cyc = 0;
        while ((busy0 || busy1 || busy2) && cyc < 2000) begin
            start = 1'b0;
            if (busy0) begin
                bc0++;
                if (vq.size() > 0) begin
                    v = vq.pop_front();
                    check("vec", {a0, b0}, v);
                end
            end
            bc1 += int'(busy1);
            bc2 += int'(busy2);
            if (cyc == abort_at) begin
                check("err_before_rst", ec0, e_part);
                rst_n = 1'b0;
                #1;
                check("rst_ab_err", {a0, b0, ec0}, 0);
                check("rst_fail_flags", {fa0, fb0, busy0, done0, pass0, busy1, done1, busy2, done2}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (cyc == restart_at) start = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("timeout", cyc < 2000, 1);
        check("vec_left", vq.size(), 0);
        check("busy_len_lat0", bc0, NV + NR);
        check("busy_len_lat2", bc1, NV + NR + 2);
        check("busy_len_mis", bc2, NV + NR);
        check("done", done0, 1);
        check("pass", pass0, e_err == 0);
        check("err_count", ec0, e_err);
        check("fail_a", fa0, efa);
        check("fail_b", fb0, efb);
        check("lat2_done_pass", {done1, pass1}, 2'b11);
        check("lat2_err", ec1, 0);
        check("mis_lat_done_pass", {done2, pass2}, 2'b10);
    endtask

    initial begin
        #12;
        check("reset_ab_err", {a0, b0, ec0, ec1}, 0);
        check("reset_flags", {fa0, fb0, busy0, done0, pass0, busy1, done1, pass1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, -1, -1);
        run(1, -1, -1);
        run(2, -1, -1);
        run(0, 50, -1);
        run(1, -1, 64);
        run(0, -1, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
